pc_stack: RTL and testbench

Parametrised program counter for the SAP-2/SAP-3 generation. It adds a number of things the SAP-1 counter lacks:
- configurable address width and reset vector;
- direct load for jumps;
- an internal return-address LIFO for CALL/RET;
- sticky overflow and underflow error flags.

It sits between the control sequencer and the memory address register. Its value is driven onto the address path whenever the sequencer asserts `oe`.

---
 rtl/sap_pkg.sv | 27 ++
 rtl/pc_ret_stack.sv | 50 +++++
 rtl/pc_stack.sv | 85 ++++++++
 tb/tb_pc_stack.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-2/SAP-3 program counter and its sequencer.
// The command encoding is common to both so the sequencer can issue it directly.
package sap_pkg;

  localparam int SAP_ADDR_W = 16;

  typedef enum logic [2:0] {
    PC_NOP  = 3'd0,
    PC_INC  = 3'd1,
    PC_LD   = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_cmd_e;

  // Only the strongest asserted command acts: ret > call > ld > inc.
  function automatic pc_cmd_e pc_decode(input logic ret, input logic call,
                                        input logic ld, input logic inc);
    pc_cmd_e cmd;
    cmd = PC_NOP;
    if (ret)       cmd = PC_RET;
    else if (call) cmd = PC_CALL;
    else if (ld)   cmd = PC_LD;
    else if (inc)  cmd = PC_INC;
    return cmd;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO built on a register array with a combinational top-of-stack read.
// Push-when-full and pop-when-empty are ignored here; the caller raises the error flags.
module pc_ret_stack #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            din,
  output logic [ADDR_W-1:0]            dout,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         full,
  output logic                         empty
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d, top_idx;
  logic              do_push, do_pop;

  assign full    = (sp_q == SP_W'(STACK_DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = sp_q - SP_W'(1);
  assign dout    = mem_q[top_idx[IDX_W-1:0]];
  assign sp      = sp_q;

  assign do_pop  = pop && !empty;
  assign do_push = push && !pop && !full;

  always_comb begin
    sp_d = sp_q;
    if (do_pop)       sp_d = sp_q - SP_W'(1);
    else if (do_push) sp_d = sp_q + SP_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  // Entries are deliberately left untouched by reset; only sp defines validity.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[sp_q[IDX_W-1:0]] <= din;
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with jump load, CALL/RET return stack and sticky stack error flags.
// bus_out is a zero-gated copy of the PC so several sources can be OR-ed onto the address path.
module pc_stack
  import sap_pkg::*;
#(
  parameter int              ADDR_W      = SAP_ADDR_W,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RST_ADDR  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc,
  input  logic                         ld,
  input  logic                         call,
  input  logic                         ret,
  input  logic [ADDR_W-1:0]            ld_addr,
  input  logic                         oe,
  input  logic                         clr_err,
  output logic [ADDR_W-1:0]            out,
  output logic [ADDR_W-1:0]            bus_out,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         stack_empty,
  output logic                         stack_full,
  output logic                         ovf,
  output logic                         unf
);

  pc_cmd_e           cmd;
  logic [ADDR_W-1:0] pc_q, pc_d, ret_addr;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  assign cmd = pc_decode(ret, call, ld, inc);

  pc_ret_stack #(
    .ADDR_W     (ADDR_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (cmd == PC_CALL),
    .pop  (cmd == PC_RET),
    .din  (pc_q),
    .dout (ret_addr),
    .sp   (sp),
    .full (stack_full),
    .empty(stack_empty)
  );

  always_comb begin
    pc_d  = pc_q;
    ovf_d = clr_err ? 1'b0 : ovf_q;
    unf_d = clr_err ? 1'b0 : unf_q;
    unique case (cmd)
      PC_INC: pc_d = pc_q + ADDR_W'(1);
      PC_LD:  pc_d = ld_addr;
      PC_CALL: begin
        if (stack_full) ovf_d = 1'b1;
        else            pc_d  = ld_addr;
      end
      PC_RET: begin
        if (stack_empty) unf_d = 1'b1;
        else             pc_d  = ret_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RST_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign out     = pc_q;
  assign bus_out = oe ? pc_q : '0;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: stimulus pushes model predictions, a monitor pops and compares
// them one time unit after each rising edge.
module tb_pc_stack;

  localparam int          AW    = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] RSTA  = 16'h0100;

  logic          clk = 1'b0;
  logic          rst, inc, ld, call, ret, oe, clr_err;
  logic [15:0]   ld_addr;
  logic [15:0]   out, bus_out;
  logic [2:0]    sp;
  logic          stack_empty, stack_full, ovf, unf;

  pc_stack #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .RST_ADDR(RSTA)) dut (
    .clk(clk), .rst(rst), .inc(inc), .ld(ld), .call(call), .ret(ret),
    .ld_addr(ld_addr), .oe(oe), .clr_err(clr_err), .out(out), .bus_out(bus_out),
    .sp(sp), .stack_empty(stack_empty), .stack_full(stack_full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    int          sp;
    bit          ovf;
    bit          unf;
    bit          oe;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  bit          m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc = RSTA;
    m_stack.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic step(input bit i, input bit l, input bit c, input bit r, input bit clr,
                      input bit o, input logic [15:0] a, input string tag);
    exp_t e;
    bit   ovf_ev, unf_ev;
    @(negedge clk);
    inc = i; ld = l; call = c; ret = r; clr_err = clr; oe = o; ld_addr = a;
    ovf_ev = 0;
    unf_ev = 0;
    if (r) begin
      if (m_stack.size() == 0) unf_ev = 1;
      else                     m_pc = m_stack.pop_back();
    end else if (c) begin
      if (m_stack.size() == DEPTH) ovf_ev = 1;
      else begin
        m_stack.push_back(m_pc);
        m_pc = a;
      end
    end else if (l) begin
      m_pc = a;
    end else if (i) begin
      m_pc = m_pc + 16'd1;
    end
    m_ovf = (clr ? 1'b0 : m_ovf) | ovf_ev;
    m_unf = (clr ? 1'b0 : m_unf) | unf_ev;
    e.pc = m_pc; e.sp = m_stack.size(); e.ovf = m_ovf; e.unf = m_unf; e.oe = o; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    inc = 0; ld = 0; call = 0; ret = 0; clr_err = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    inc = 0; ld = 0; call = 0; ret = 0; clr_err = 0;
    rst = 1;
    model_reset();
    #1;
    chk({tag, "_out"}, 32'(out), 32'(RSTA));
    chk({tag, "_sp"}, 32'(sp), 0);
    chk({tag, "_empty"}, 32'(stack_empty), 1);
    chk({tag, "_flags"}, {30'd0, ovf, unf}, 0);
    @(negedge clk);
    rst = 0;
  endtask

  // Monitor: one comparison set per issued command.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, "_out"}, 32'(out), 32'(e.pc));
      chk({e.tag, "_sp"}, 32'(sp), 32'(e.sp));
      chk({e.tag, "_empty"}, 32'(stack_empty), 32'(e.sp == 0));
      chk({e.tag, "_full"}, 32'(stack_full), 32'(e.sp == DEPTH));
      chk({e.tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
      chk({e.tag, "_unf"}, 32'(unf), 32'(e.unf));
      chk({e.tag, "_bus"}, 32'(bus_out), e.oe ? 32'(e.pc) : 0);
      $display("txn %-10s out=%h sp=%0d full=%0b empty=%0b ovf=%0b unf=%0b bus=%h",
               e.tag, out, sp, stack_full, stack_empty, ovf, unf, bus_out);
    end
  end

  initial begin
    rst = 1; inc = 0; ld = 0; call = 0; ret = 0; clr_err = 0; oe = 0; ld_addr = '0;
    model_reset();
    #2;
    chk("por_out", 32'(out), 32'(RSTA));
    chk("por_sp", 32'(sp), 0);
    chk("por_empty_full", {30'd0, stack_empty, stack_full}, 32'b10);
    chk("por_bus_off", 32'(bus_out), 0);
    oe = 1;
    #1;
    chk("por_bus_on", 32'(bus_out), 32'(RSTA));
    oe = 0;
    @(negedge clk);
    rst = 0;

    // Increment from reset vector
    repeat (3) step(1, 0, 0, 0, 0, 0, 16'h0, "inc");
    // Wrap and ld-beats-inc
    step(0, 1, 0, 0, 0, 1, 16'hFFFF, "ld_ffff");
    step(1, 0, 0, 0, 0, 1, 16'h0, "wrap");
    step(1, 1, 0, 0, 0, 0, 16'h1234, "ld_inc");
    // Nested call / ret
    step(0, 1, 0, 0, 0, 0, 16'h0010, "ld_0010");
    step(0, 0, 1, 0, 0, 1, 16'h0200, "call200");
    step(0, 0, 1, 0, 0, 1, 16'h0300, "call300");
    step(0, 0, 0, 1, 0, 1, 16'h0, "ret1");
    step(0, 0, 0, 1, 0, 1, 16'h0, "ret2");
    // Fill, overflow, clear
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0, 0, 16'h0400 + 16'(k), "fill");
    step(0, 0, 0, 0, 1, 0, 16'h0, "clr_ovf");
    // Drain, underflow, call+ret collision
    repeat (4) step(0, 0, 0, 1, 0, 0, 16'h0, "drain");
    step(0, 0, 0, 1, 0, 0, 16'h0, "ret_empty");
    step(0, 0, 1, 0, 0, 0, 16'h0555, "call1");
    step(0, 0, 1, 1, 0, 0, 16'h0777, "call_ret");
    // Error set wins over clear
    step(0, 0, 0, 1, 1, 0, 16'h0, "clr_vs_unf");
    step(0, 0, 0, 0, 1, 0, 16'h0, "clr_unf");

    // Combinational oe gating, no clock edge involved
    idle();
    oe = 1;
    #1 chk("oe_on", 32'(bus_out), 32'(m_pc));
    oe = 0;
    #1 chk("oe_off", 32'(bus_out), 0);

    // Mid-sequence reset with three entries occupied
    do_reset("rst_clean");
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 0, 16'h0A00 + 16'(k), "pre_rst");
    do_reset("rst_mid");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, a, "rand");
    end
    idle();
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
